// File: rtl/bc_display_driver.sv
// rtl/bc_display_driver.sv - 8-digit multiplexed 7-segment driver with double-buffered frame and blink
//
// Purpose: double-buffers an 8-glyph frame supplied by game logic, scans one anode
//          per refresh tick, decodes 5-bit glyph codes to active-low segments and
//          optionally blinks the whole display.
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        synchronous active-low reset
//   i_load         1-cycle strobe capturing i_glyphs into the shadow buffer
//   i_glyphs       8 x 5-bit glyph codes, [5*i +: 5] drives anode i (0 = rightmost)
//   i_blink_en     1 = blink whole display, 0 = steady
//   o_an           anode enables, active-low, at most one bit low
//   o_digit        segments {g,f,e,d,c,b,a}, active-low
//   o_frame_done   1-cycle pulse when the scan wraps from digit 7 to digit 0

module bc_display_driver #(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLINK_FRAMES = 62
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [39:0] i_glyphs,
    input  logic        i_blink_en,
    output logic [7:0]  o_an,
    output logic [6:0]  o_digit,
    output logic        o_frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [39:0]   ALL_BLANK  = {8{5'd16}};

    typedef enum logic {S_DARK, S_SCAN} state_t;

    state_t         r_state, w_state_next;
    logic [PW-1:0]  r_prescale, w_prescale_next;
    logic [2:0]     r_index, w_index_next;
    logic [39:0]    r_shadow, w_shadow_next;
    logic [39:0]    r_active, w_active_next;
    logic           r_pending, w_pending_next;
    logic           r_phase_on, w_phase_on_next;
    logic [FW-1:0]  r_frame_cnt, w_frame_cnt_next;
    logic           w_tick, w_boundary;
    logic [4:0]     w_glyph;
    logic [7:0]     w_an_next;
    logic [6:0]     w_digit_next;

    function automatic logic [6:0] f_decode(input logic [4:0] code);
        case (code)
            5'd0:    f_decode = 7'b1000000;
            5'd1:    f_decode = 7'b1111001;
            5'd2:    f_decode = 7'b0100100;
            5'd3:    f_decode = 7'b0110000;
            5'd4:    f_decode = 7'b0011001;
            5'd5:    f_decode = 7'b0010010;
            5'd6:    f_decode = 7'b0000010;
            5'd7:    f_decode = 7'b1111000;
            5'd8:    f_decode = 7'b0000000;
            5'd9:    f_decode = 7'b0010000;
            5'd10:   f_decode = 7'b0001000;
            5'd11:   f_decode = 7'b0000011;
            5'd12:   f_decode = 7'b1000110;
            5'd13:   f_decode = 7'b0100001;
            5'd14:   f_decode = 7'b0000110;
            5'd15:   f_decode = 7'b0001110;
            5'd17:   f_decode = 7'b0001100;  // P
            5'd18:   f_decode = 7'b0000011;  // b
            5'd19:   f_decode = 7'b1000110;  // C
            5'd20:   f_decode = 7'b0111111;  // -
            5'd21:   f_decode = 7'b1000111;  // L
            5'd22:   f_decode = 7'b0100011;  // o
            default: f_decode = 7'b1111111;  // BLANK (16, 23-31)
        endcase
    endfunction

    assign w_tick     = (r_state == S_SCAN) && (r_prescale == PRESC_LAST);
    assign w_boundary = w_tick && (r_index == 3'd7);

    // State register
    always_ff @(posedge i_clock) begin
        if (!i_reset) r_state <= S_DARK;
        else          r_state <= w_state_next;
    end

    // Next-state logic: only reset returns to DARK
    always_comb begin
        w_state_next = r_state;
        if (r_state == S_DARK && i_load) w_state_next = S_SCAN;
    end

    // Datapath next values
    always_comb begin
        w_prescale_next  = '0;
        w_index_next     = '0;
        w_shadow_next    = i_load ? i_glyphs : r_shadow;
        w_active_next    = r_active;
        w_pending_next   = r_pending;
        w_phase_on_next  = r_phase_on;
        w_frame_cnt_next = r_frame_cnt;

        if (r_state == S_DARK) begin
            // First frame skips the shadow stage so the display lights immediately
            if (i_load) begin
                w_active_next  = i_glyphs;
                w_pending_next = 1'b0;
            end
        end else begin
            w_prescale_next = w_tick ? '0 : r_prescale + 1'b1;
            w_index_next    = w_tick ? r_index + 3'd1 : r_index;
            if (w_boundary) begin
                // A load arriving on the boundary cycle itself is folded in here
                if (r_pending || i_load) w_active_next = w_shadow_next;
                w_pending_next = 1'b0;
            end else if (i_load) begin
                w_pending_next = 1'b1;
            end
        end

        if (!i_blink_en) begin
            w_phase_on_next  = 1'b1;
            w_frame_cnt_next = '0;
        end else if (w_boundary) begin
            if (r_frame_cnt == FRAME_LAST) begin
                w_frame_cnt_next = '0;
                w_phase_on_next  = ~r_phase_on;
            end else begin
                w_frame_cnt_next = r_frame_cnt + 1'b1;
            end
        end
    end

    // Output logic: computed from next-state values so the registered outputs
    // move on the same edge as the index and the committed buffer
    always_comb begin
        w_glyph      = w_active_next[5*w_index_next +: 5];
        w_an_next    = 8'hFF;
        w_digit_next = 7'h7F;
        if (w_state_next == S_SCAN) begin
            w_digit_next = f_decode(w_glyph);
            if (w_phase_on_next) w_an_next = ~(8'b1 << w_index_next);
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_prescale   <= '0;
            r_index      <= '0;
            r_shadow     <= ALL_BLANK;
            r_active     <= ALL_BLANK;
            r_pending    <= 1'b0;
            r_phase_on   <= 1'b1;
            r_frame_cnt  <= '0;
            o_an         <= 8'hFF;
            o_digit      <= 7'h7F;
            o_frame_done <= 1'b0;
        end else begin
            r_prescale   <= w_prescale_next;
            r_index      <= w_index_next;
            r_shadow     <= w_shadow_next;
            r_active     <= w_active_next;
            r_pending    <= w_pending_next;
            r_phase_on   <= w_phase_on_next;
            r_frame_cnt  <= w_frame_cnt_next;
            o_an         <= w_an_next;
            o_digit      <= w_digit_next;
            o_frame_done <= w_boundary;
        end
    end

endmodule

// File: tb/tb_bc_display_driver.sv
// tb/tb_bc_display_driver.sv - directed self-checking bench for bc_display_driver
module tb_bc_display_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [39:0] glyphs;
    logic        blink_en;
    logic [7:0]  an;
    logic [6:0]  digit;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    bc_display_driver #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
        .i_clock      (clk),
        .i_reset      (reset),
        .i_load       (load),
        .i_glyphs     (glyphs),
        .i_blink_en   (blink_en),
        .o_an         (an),
        .o_digit      (digit),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled on the falling edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    logic [6:0] exp_s2 [8] = '{7'b1111001, 7'b0100100, 7'b0000011, 7'b1000110,
                              7'h7F, 7'h7F, 7'h7F, 7'h7F};
    // Glyph pattern for the boundary-cycle load: P - L o F E d 27
    logic [4:0] pat_code [8] = '{5'd17, 5'd20, 5'd21, 5'd22, 5'd15, 5'd14, 5'd13, 5'd27};
    logic [6:0] pat_seg  [8] = '{7'b0001100, 7'b0111111, 7'b1000111, 7'b0100011,
                                7'b0001110, 7'b0000110, 7'b0100001, 7'h7F};
    logic       blink_on [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        reset    = 1'b0;
        load     = 1'b0;
        glyphs   = '0;
        blink_en = 1'b0;

        // 1. reset and idle
        step(3);
        check("rst_an", an, 8'hFF);
        check("rst_digit", {1'b0, digit}, 8'h7F);
        check("rst_fd", {7'b0, frame_done}, 8'h00);
        reset = 1'b1;
        step(50);
        check("idle_an", an, 8'hFF);
        check("idle_digit", {1'b0, digit}, 8'h7F);

        // 2. first load goes straight to the display
        glyphs = {{4{5'd16}}, 5'd19, 5'd18, 5'd2, 5'd1};
        load   = 1'b1;
        step(1);
        load   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("s2_an%0d", i), an, ~(8'b1 << i));
            check($sformatf("s2_dg%0d", i), {1'b0, digit}, {1'b0, exp_s2[i]});
            check($sformatf("s2_fd%0d", i), {7'b0, frame_done}, 8'h00);
            step(4);
        end
        check("s2_wrap_fd", {7'b0, frame_done}, 8'h01);
        check("s2_wrap_an", an, 8'hFE);

        // 3. load during index 3 commits only at the frame boundary
        step(12);
        glyphs = '0;
        load   = 1'b1;
        step(1);
        load   = 1'b0;
        step(3);
        for (int i = 4; i < 8; i++) begin
            check($sformatf("s3_an%0d", i), an, ~(8'b1 << i));
            check($sformatf("s3_old%0d", i), {1'b0, digit}, 8'h7F);
            step(4);
        end
        check("s3_fd", {7'b0, frame_done}, 8'h01);
        check("s3_an0", an, 8'hFE);
        check("s3_new0", {1'b0, digit}, 8'h40);

        // 4. last load wins; load on the boundary cycle commits at that boundary
        glyphs = {8{5'd5}};
        load   = 1'b1;
        step(1);
        load   = 1'b0;
        step(7);
        glyphs = {8{5'd7}};
        load   = 1'b1;
        step(1);
        load   = 1'b0;
        check("s4_mid_an", an, 8'hFB);
        check("s4_mid_dg", {1'b0, digit}, 8'h40);
        step(19);
        check("s4_idx7_dg", {1'b0, digit}, 8'h40);
        step(4);
        check("s4_fd", {7'b0, frame_done}, 8'h01);
        check("s4_last_wins", {1'b0, digit}, 8'h78);
        step(31);
        for (int i = 0; i < 8; i++) glyphs[5*i +: 5] = pat_code[i];
        load = 1'b1;
        step(1);
        load = 1'b0;
        check("s4b_fd", {7'b0, frame_done}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("s4b_an%0d", i), an, ~(8'b1 << i));
            check($sformatf("s4b_dg%0d", i), {1'b0, digit}, {1'b0, pat_seg[i]});
            step(4);
        end

        // 5. blink: two frames on, two frames dark, frame_done every 32 clocks
        blink_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            step(16);
            check($sformatf("s5_an_f%0d", f), an, blink_on[f] ? 8'hEF : 8'hFF);
            step(16);
            check($sformatf("s5_fd_f%0d", f), {7'b0, frame_done}, 8'h01);
        end
        step(8);
        check("s5_off_an", an, 8'hFF);
        blink_en = 1'b0;
        step(1);
        check("s5_resume_an", an, 8'hFB);

        // 6. reset mid-frame drops pending load; display stays dark until a load
        glyphs = {8{5'd8}};
        load   = 1'b1;
        step(1);
        load   = 1'b0;
        step(10);
        check("s6_pre_an", an, 8'hDF);
        reset = 1'b0;
        step(1);
        check("s6_rst_an", an, 8'hFF);
        check("s6_rst_dg", {1'b0, digit}, 8'h7F);
        check("s6_rst_fd", {7'b0, frame_done}, 8'h00);
        reset = 1'b1;
        step(50);
        check("s6_dark_an", an, 8'hFF);
        check("s6_dark_fd", {7'b0, frame_done}, 8'h00);
        glyphs = {{7{5'd16}}, 5'd27};
        load   = 1'b1;
        step(1);
        load   = 1'b0;
        check("s6_load_an", an, 8'hFE);
        check("s6_code27", {1'b0, digit}, 8'h7F);
        step(4);
        check("s6_an1", an, 8'hFD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
